// File: rtl/wr_arb_pkg.sv
// rtl/wr_arb_pkg.sv - shared constants, types and helpers for the write-port arbiter
package wr_arb_pkg;

    localparam int unsigned NUM_PORTS = 8;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned RF_DEPTH  = 40;
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS);

    typedef logic [NUM_PORTS-1:0] port_onehot_t;

    // Encode a one-hot (or zero) port vector to its index; zero maps to 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input port_onehot_t oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// rtl/rr_pick_8.sv - combinational rotate-priority picker, search starts after last_grant
module rr_pick_8
    import wr_arb_pkg::*;
(
    input  logic         [NUM_PORTS-1:0] req_valid,
    input  port_onehot_t                 last_grant,
    output port_onehot_t                 grant
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the ports from last_grant+1 around to last_grant itself; first valid one wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        base  = onehot_to_idx(last_grant);
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = base + IDX_W'(k);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_port_rr_arbiter_8.sv
// rtl/wr_port_rr_arbiter_8.sv - round-robin write-port arbiter with registered issue stage (option: WR_ARB_PERF_CNT_EN)
module wr_port_rr_arbiter_8
    import wr_arb_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]    req_data,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic                           wr_stall,
    input  logic                           err_clr,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [DATA_W-1:0]              wr_data,
    output logic [NUM_PORTS-1:0]           wr_select,
    output logic                           addr_err
`ifdef WR_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                    conflict_cnt
`endif
);

    port_onehot_t       last_grant;
    port_onehot_t       pick;
    logic               grant_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               in_range;

    rr_pick_8 u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // A stalled register file blocks every grant so nothing is consumed that cannot be issued.
    always_comb begin
        req_ready = wr_stall ? '0 : pick;
        grant_any = |req_ready;
    end

    // Route the winning port's address and data toward the issue register.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        in_range = (sel_addr < ADDR_W'(RF_DEPTH));
    end

    // Issue register and rotate pointer; address/data hold when idle, enable/select drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_select  <= '0;
            last_grant <= port_onehot_t'(1) << (NUM_PORTS - 1);
        end else if (grant_any) begin
            wr_en      <= in_range;
            wr_addr    <= sel_addr;
            wr_data    <= sel_data;
            wr_select  <= req_ready;
            last_grant <= req_ready;
        end else begin
            wr_en      <= 1'b0;
            wr_select  <= '0;
        end
    end

    // Sticky out-of-range flag; a new error in the same cycle as err_clr keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (grant_any && !in_range) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

`ifdef WR_ARB_PERF_CNT_EN
    logic multi_valid;

    always_comb begin
        multi_valid = |(req_valid & (req_valid - NUM_PORTS'(1)));
    end

    // Saturating count of unstalled cycles in which two or more ports competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (!wr_stall && multi_valid && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
